log2_iter: RTL and testbench

- Base-2 logarithm: the inverse companion of the anti-log block.
- Input is unsigned 16.8 fixed-point (24 bits). Output is 4.6 fixed-point (10 bits), the same format the anti-log block accepts, so log then anti-log round-trips a value within truncation error.
- Multi-cycle iterative engine with valid/ready handshakes on both sides.
- Sits between sample sources and log-domain arithmetic (gain, multiply-by-add).

---
 rtl/log2_pkg.sv | 22 ++
 rtl/log2_iter_if.sv | 27 ++
 rtl/log2_lzd.sv | 22 ++
 rtl/log2_iter.sv | 116 +++++++++++
 tb/tb_log2_iter.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/log2_pkg.sv
// Shared definitions for the iterative base-2 logarithm engine.
// Holds the FSM state encoding, the operand/result widths and the derived
// iteration-counter width. No ports.
package log2_pkg;

   localparam int IN_W     = 24;                    // operand width, 16.8
   localparam int IN_FRAC  = 8;                     // operand fractional bits
   localparam int OUT_FRAC = 6;                     // result fraction bits = squaring steps
   localparam int MANT_W   = 24;                    // normalised mantissa, 1.23
   localparam int OUT_INT  = 4;                     // result integer bits
   localparam int OUT_W    = OUT_INT + OUT_FRAC;    // result width, 4.6
   localparam int POS_W    = $clog2(IN_W);          // leading-one index width
   localparam int CNT_W    = $clog2(OUT_FRAC + 1);  // iteration counter width

   typedef enum logic [1:0] {
      IDLE,
      NORM,
      ITER,
      DONE
   } state_t;

endpackage

// File: rtl/log2_iter_if.sv
// Operand/result handshake bundle for log2_iter.
//   in_valid/in_ready/in_data     : operand channel, unsigned 16.8
//   out_valid/out_ready/out_data  : result channel, 4.6
//   out_uflow                     : operand was below 1.0, result forced to 0
// master = operand source / result sink, slave = the log2 engine.
interface log2_iter_if;
   import log2_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_data;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic             out_uflow;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_uflow
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_uflow
   );

endinterface

// File: rtl/log2_lzd.sv
// Combinational leading-one detector.
//   din      : value to scan
//   pos      : index of the most significant set bit (0 when din is zero)
//   all_zero : din has no bits set
module log2_lzd
   import log2_pkg::*;
(
   input  logic [IN_W-1:0]  din,
   output logic [POS_W-1:0] pos,
   output logic             all_zero
);

   always_comb begin
      pos      = '0;
      all_zero = (din == '0);
      // Ascending scan: the last hit is the highest set bit.
      for (int i = 0; i < IN_W; i++) begin
         if (din[i]) pos = POS_W'(i);
      end
   end

endmodule

// File: rtl/log2_iter.sv
// Iterative base-2 logarithm: 16.8 unsigned operand in, 4.6 result out.
// The integer part comes from the leading-one position; each fraction bit
// comes from one squaring of the normalised 1.23 mantissa (truncating).
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, aborts any operation in flight
//   bus  : operand/result handshake bundle (slave side)
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand
// NORM  | locate leading one, split integer part and mantissa, catch < 1.0
// ITER  | one squaring step per cycle, OUT_FRAC steps
// DONE  | out_valid high, result held until out_ready
module log2_iter
   import log2_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   log2_iter_if.slave   bus
);

   state_t             state;
   logic [IN_W-1:0]    opnd;
   logic [MANT_W-1:0]  mant;
   logic [CNT_W-1:0]   cnt;
   logic               in_ready_q;
   logic               out_valid_q;
   logic               out_uflow_q;
   logic [OUT_W-1:0]   out_data_q;

   logic [POS_W-1:0]   lead_pos;
   logic               lead_zero;
   logic               below_one;
   logic [OUT_INT-1:0] int_part;
   logic [MANT_W-1:0]  norm_mant;
   logic [MANT_W:0]    sq_top;
   logic               sq_hi;
   logic [MANT_W-1:0]  next_mant;

   log2_lzd u_lzd (
      .din      (opnd),
      .pos      (lead_pos),
      .all_zero (lead_zero)
   );

   assign below_one = lead_zero || (lead_pos < POS_W'(IN_FRAC));
   assign int_part  = OUT_INT'(lead_pos - POS_W'(IN_FRAC));
   assign norm_mant = opnd << (POS_W'(IN_W - 1) - lead_pos);

   // Square is 2.46; only the top MANT_W+1 bits matter for either
   // renormalisation choice, the rest is truncated away.
   assign sq_top    = (MANT_W + 1)'(({{MANT_W{1'b0}}, mant} * {{MANT_W{1'b0}}, mant}) >> (MANT_W - 1));
   assign sq_hi     = sq_top[MANT_W];
   assign next_mant = sq_hi ? sq_top[MANT_W:1] : sq_top[MANT_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         opnd        <= '0;
         mant        <= '0;
         cnt         <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_uflow_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               in_ready_q <= 1'b1;
               if (bus.in_valid && in_ready_q) begin
                  opnd       <= bus.in_data;
                  in_ready_q <= 1'b0;
                  state      <= NORM;
               end
            end
            NORM: begin
               if (below_one) begin
                  out_data_q  <= '0;
                  out_uflow_q <= 1'b1;
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end else begin
                  out_data_q  <= {int_part, {OUT_FRAC{1'b0}}};
                  out_uflow_q <= 1'b0;
                  mant        <= norm_mant;
                  cnt         <= '0;
                  state       <= ITER;
               end
            end
            ITER: begin
               mant <= next_mant;
               // Shift-in keeps the first fraction bit landing in the MSB.
               out_data_q[OUT_FRAC-1:0] <= {out_data_q[OUT_FRAC-2:0], sq_hi};
               cnt  <= cnt + 1'b1;
               if (cnt == CNT_W'(OUT_FRAC - 1)) begin
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_uflow = out_uflow_q;

endmodule

// File: tb/tb_log2_iter.sv
// Self-checking bench for log2_iter: directed vector table, random operands
// against a real-arithmetic log2 model, back-to-back throughput, output
// stall and mid-operation reset.
module tb_log2_iter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   log2_iter_if bus ();

   log2_iter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Negedge monitor: cycle of each accept, each out_valid rise, each result.
   int          acc_q[$];
   int          rise_q[$];
   logic [10:0] res_q[$];
   logic        prev_ov = 1'b0;
   always @(negedge clk) begin
      if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
      if (bus.out_valid && !prev_ov) rise_q.push_back(cyc);
      if (bus.out_valid && bus.out_ready) res_q.push_back({bus.out_uflow, bus.out_data});
      prev_ov = bus.out_valid;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: floor(64*log2(x/256)); near flags a value within 2^-18
   // (in log2 units) above a code boundary, where one LSB low is tolerated.
   function automatic void ref_log(input logic [23:0] x, output logic [9:0] d,
                                   output logic u, output bit near);
      real v;
      if (x < 24'h000100) begin
         d = '0; u = 1'b1; near = 1'b0;
      end else begin
         v    = 64.0 * $ln(real'(x) / 256.0) / $ln(2.0) + 1.0e-9;
         d    = 10'($rtoi($floor(v)));
         near = (v - $floor(v)) < (64.0 / 262144.0);
         u    = 1'b0;
      end
   endfunction

   task automatic check_log(input string name, input logic [23:0] x,
                            input logic [9:0] act_d, input logic act_u);
      logic [9:0] ed;
      logic       eu;
      bit         near;
      bit         ok;
      ref_log(x, ed, eu, near);
      ok = (act_u === eu) && ((act_d === ed) || (near && act_d === ed - 10'd1));
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s x=0x%06h: got data=0x%03h uflow=%0b expected data=0x%03h uflow=%0b",
                  name, x, act_d, act_u, ed, eu);
      end
   endtask

   task automatic clear_q();
      acc_q.delete();
      rise_q.delete();
      res_q.delete();
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk); #1;
         ok = bus.in_ready;
      end
   endtask

   task automatic run_one(input logic [23:0] x, output logic [9:0] d, output logic u,
                          output int lat, output bit tmo);
      bit got;
      clear_q();
      d = '0; u = 1'b0; lat = -1; tmo = 1'b0;
      wait_ready(got);
      if (!got) begin
         tmo = 1'b1;
      end else begin
         @(posedge clk); #1;
         bus.in_valid  = 1'b1;
         bus.in_data   = x;
         bus.out_ready = 1'b1;
         @(posedge clk); #1;
         bus.in_valid  = 1'b0;
         bus.in_data   = 24'($urandom);
         got = 1'b0;
         for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk); #1;
            got = (res_q.size() != 0);
         end
         if (!got) tmo = 1'b1;
         else begin
            {u, d} = res_q[0];
            if (acc_q.size() > 0 && rise_q.size() > 0) lat = rise_q[0] - acc_q[0];
         end
      end
   endtask

   typedef struct {
      logic [23:0] x;
      logic [9:0]  d;
      logic        u;
      int          lat;
   } vec_t;

   initial begin
      vec_t        vecs[8];
      logic [23:0] ops[8];
      logic [23:0] x;
      logic [31:0] mask;
      logic [9:0]  d;
      logic        u;
      int          lat;
      int          idx;
      bit          tmo;
      bit          got;

      vecs[0] = '{24'h000100, 10'h000, 1'b0, 8};
      vecs[1] = '{24'h000200, 10'h040, 1'b0, 8};
      vecs[2] = '{24'h800000, 10'h3C0, 1'b0, 8};
      vecs[3] = '{24'h000300, 10'h065, 1'b0, 8};
      vecs[4] = '{24'hFFFFFF, 10'h3FF, 1'b0, 8};
      vecs[5] = '{24'h0000FF, 10'h000, 1'b1, 2};
      vecs[6] = '{24'h000000, 10'h000, 1'b1, 2};
      vecs[7] = '{24'h000180, 10'h025, 1'b0, 8};

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      check("rst in_ready",  bus.in_ready,  0);
      check("rst out_valid", bus.out_valid, 0);
      check("rst out_data",  bus.out_data,  0);
      check("rst out_uflow", bus.out_uflow, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk); #1;
      check("in_ready before first edge", bus.in_ready, 0);
      @(negedge clk); #1;
      check("in_ready after first edge", bus.in_ready, 1);

      // Directed vectors
      for (int i = 0; i < 8; i++) begin
         run_one(vecs[i].x, d, u, lat, tmo);
         check($sformatf("vec%0d timeout", i), tmo, 0);
         check($sformatf("vec%0d data", i), d, vecs[i].d);
         check($sformatf("vec%0d uflow", i), u, vecs[i].u);
         check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      end

      // Random single operands across all magnitudes
      for (int i = 0; i < 12; i++) begin
         mask = (32'd1 << $urandom_range(6, 24)) - 32'd1;
         x    = 24'($urandom & mask);
         run_one(x, d, u, lat, tmo);
         check($sformatf("rnd%0d timeout", i), tmo, 0);
         check_log($sformatf("rnd%0d", i), x, d, u);
         check($sformatf("rnd%0d latency", i), lat, (x < 24'h000100) ? 2 : 8);
      end

      // Back-to-back with in_valid and out_ready held high
      for (int i = 0; i < 8; i++) begin
         mask   = (32'd1 << $urandom_range(9, 24)) - 32'd1;
         ops[i] = 24'($urandom & mask) | 24'h000100;
      end
      clear_q();
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = ops[0];
      idx = 0;
      for (int c = 0; c < 200 && idx < 8; c++) begin
         @(posedge clk); #1;
         if (acc_q.size() > idx) begin
            idx++;
            if (idx < 8) bus.in_data = ops[idx];
            else         bus.in_valid = 1'b0;
         end
      end
      bus.in_valid = 1'b0;
      check("b2b accepted count", idx, 8);
      got = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
         @(negedge clk); #1;
         got = (res_q.size() >= 8);
      end
      check("b2b result count", res_q.size(), 8);
      for (int i = 1; i < 8 && i < acc_q.size(); i++)
         check($sformatf("b2b spacing %0d", i), acc_q[i] - acc_q[i-1], 9);
      for (int i = 0; i < 8 && i < res_q.size(); i++)
         check_log($sformatf("b2b%0d", i), ops[i], res_q[i][9:0], res_q[i][10]);

      // Output stall: result held, new operand refused
      wait_ready(got);
      check("bp ready timeout", got, 1);
      clear_q();
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 24'h000300;
      @(posedge clk); #1;
      bus.in_valid  = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
         @(negedge clk); #1;
         got = bus.out_valid;
      end
      check("bp valid timeout", got, 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data  = 24'h000200;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk); #1;
         check($sformatf("bp hold %0d", c),
               {bus.out_valid, bus.in_ready, bus.out_uflow, bus.out_data},
               {1'b1, 1'b0, 1'b0, 10'h065});
      end
      @(posedge clk); #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk); #1;
      check("bp release out_valid", bus.out_valid, 0);
      check("bp release in_ready",  bus.in_ready,  1);
      repeat (12) @(negedge clk);
      #1;
      check("bp accepts", acc_q.size(), 1);
      check("bp results", res_q.size(), 1);
      check("bp no stray result", bus.out_valid, 0);

      // Reset in the middle of the squaring iterations
      wait_ready(got);
      check("rst-mid ready timeout", got, 1);
      @(posedge clk); #1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 24'hFFFFFF;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("rst-mid out_valid", bus.out_valid, 0);
      check("rst-mid in_ready",  bus.in_ready,  0);
      check("rst-mid out_data",  bus.out_data,  0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk); #1;
      check("rst-mid ready before edge", bus.in_ready, 0);
      @(negedge clk); #1;
      check("rst-mid ready after edge", bus.in_ready, 1);
      run_one(24'h000200, d, u, lat, tmo);
      check("post-rst timeout", tmo, 0);
      check("post-rst data",    d,   10'h040);
      check("post-rst uflow",   u,   0);
      check("post-rst latency", lat, 8);
      check("post-rst single result", res_q.size(), 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
